im_bus_read_responder: RTL and testbench
========================================

IM_BUS_READ_RESPONDER -- requirements
Module: im_bus_read_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, the address width.
REQ-002 SHALL have parameter DLEN, default 32, the read data width.
REQ-003 SHALL have parameter ILEN, default 4, the transaction ID width.
REQ-004 SHALL have parameter DEPTH, default 1024, the instruction memory size in DLEN-bit words (power of 2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_im_bus_arvalid, input, 1 bit: read address valid.
REQ-008 SHALL have port o_im_bus_arready, output, 1 bit: read address ready.
REQ-009 SHALL have port i_im_bus_araddr, input, XLEN bits: byte address.
REQ-010 SHALL have port i_im_bus_arid, input, ILEN bits: transaction ID.
REQ-011 SHALL have port o_im_bus_rvalid, output, 1 bit: read data valid.
REQ-012 SHALL have port i_im_bus_rready, input, 1 bit: read data ready (from decode).
REQ-013 SHALL have port o_im_bus_rdata, output, DLEN bits: instruction word.
REQ-014 SHALL have port o_im_bus_rresp, output, 2 bits: response code (00 OKAY, 10 SLVERR, 11 DECERR).
REQ-015 SHALL have port o_im_bus_rid, output, ILEN bits: echoed arid.
REQ-016 SHALL have port i_ld_we, input, 1 bit: memory load write enable.
REQ-017 SHALL have port i_ld_addr, input, $clog2(DEPTH) bits: load word index.
REQ-018 SHALL have port i_ld_wdata, input, DLEN bits: load data.

Function
REQ-019 An AR handshake SHALL occur on a rising edge with arvalid and arready both high, and an R handshake SHALL occur on a rising edge with rvalid and rready both high.
REQ-020 The block SHALL keep an outstanding counter (0..2) that increments on an AR handshake, decrements on an R handshake, and is unchanged when both occur on the same edge.
REQ-021 arready SHALL equal (outstanding < 2) AND run, where run is a flop cleared by reset and set on the first clk edge after rstn deasserts; arready SHALL have no combinational path from rready or arvalid.
REQ-022 The memory read SHALL be synchronous, one cycle: an AR handshake at edge t SHALL make the response eligible at edge t+1, with rvalid high no earlier than the cycle following edge t.
REQ-023 Responses SHALL be held in a 2-entry in-order FIFO holding rdata, rresp and rid, with rvalid = FIFO not empty.
REQ-024 While rvalid is high and rready is low, rdata, rresp and rid SHALL hold stable until the R handshake.
REQ-025 With rready held high, the block SHALL sustain one AR and one R handshake per cycle.
REQ-026 If araddr[1:0] != 0, the response SHALL be rresp=10 and rdata=0; this check has priority over REQ-027.
REQ-027 If araddr >= DEPTH*4, the response SHALL be rresp=11 and rdata=0.
REQ-028 Otherwise the response SHALL be rresp=00 with rdata = mem[araddr[$clog2(DEPTH)+1:2]].
REQ-029 rid SHALL equal the arid captured at the AR handshake, for every response code.
REQ-030 If i_ld_we is high at an edge, mem[i_ld_addr] SHALL be written; a read of the same word on the same edge SHALL return the old data.
REQ-031 The FIFO SHALL never overflow (guaranteed by REQ-021), and no R handshake SHALL be possible while it is empty.

Reset
REQ-032 While rstn is low, o_im_bus_arready, o_im_bus_rvalid, the outstanding counter, the FIFO pointers and run SHALL be 0, and o_im_bus_rdata, o_im_bus_rresp and o_im_bus_rid SHALL be 0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset asserted mid-transaction SHALL discard all pending reads and responses immediately, with no response emitted after release.

Verification
REQ-035 Load mem[5]=0x00A00093, AR araddr=0x14 arid=3, rready=1 -> next cycle rvalid=1, rdata=0x00A00093, rresp=00, rid=3.
REQ-036 Back-to-back AR to 0x0, 0x4, 0x8 with rready=1 -> arready stays 1, three in-order responses on consecutive cycles.
REQ-037 rready=0, issue 3 ARs -> two accepted, arready=0 on the third, rvalid/rdata held stable; raise rready -> responses drain in order, then arready returns to 1.
REQ-038 araddr=0x6 -> rresp=10, rdata=0; araddr=DEPTH*4 (0x1000) -> rresp=11, rdata=0; each with the correct rid.
REQ-039 Assert rstn low with 2 responses pending -> rvalid=0 and arready=0 immediately; after release, arready=1 from the second edge and no stale response appears.

Source files
------------

// File: rtl/im_bus_if.sv
// Instruction-memory read bus: AR (address) and R (response) channels between
// the fetch requester (master) and the instruction memory responder (slave).
interface im_bus_if #(
  parameter int XLEN = 32,
  parameter int DLEN = 32,
  parameter int ILEN = 4
);
  logic            i_im_bus_arvalid;
  logic            o_im_bus_arready;
  logic [XLEN-1:0] i_im_bus_araddr;
  logic [ILEN-1:0] i_im_bus_arid;
  logic            o_im_bus_rvalid;
  logic            i_im_bus_rready;
  logic [DLEN-1:0] o_im_bus_rdata;
  logic [1:0]      o_im_bus_rresp;
  logic [ILEN-1:0] o_im_bus_rid;

  modport master (
    output i_im_bus_arvalid, i_im_bus_araddr, i_im_bus_arid, i_im_bus_rready,
    input  o_im_bus_arready, o_im_bus_rvalid, o_im_bus_rdata, o_im_bus_rresp, o_im_bus_rid
  );

  modport slave (
    input  i_im_bus_arvalid, i_im_bus_araddr, i_im_bus_arid, i_im_bus_rready,
    output o_im_bus_arready, o_im_bus_rvalid, o_im_bus_rdata, o_im_bus_rresp, o_im_bus_rid
  );
endinterface

// File: rtl/im_bus_read_responder.sv
// Instruction memory read responder: one-cycle synchronous read into a 2-entry
// in-order response FIFO, with address error checking and a side load port.
module im_bus_read_responder #(
  parameter int XLEN  = 32,
  parameter int DLEN  = 32,
  parameter int ILEN  = 4,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  im_bus_if.slave                  bus,
  input  logic                     i_ld_we,
  input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
  input  logic [DLEN-1:0]          i_ld_wdata
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic       run_reg;
  logic [1:0] outstanding_reg, outstanding_next;
  logic       wr_ptr_reg, wr_ptr_next;
  logic       rd_ptr_reg, rd_ptr_next;

  logic       arready;
  logic       rvalid;
  logic       ar_hs;
  logic       r_hs;

  logic          misaligned;
  logic          out_of_range;
  logic [1:0]    resp_code;
  logic [AW-1:0] word_idx;

  logic [DLEN-1:0] mem [DEPTH];

  logic [DLEN-1:0] fifo_rdata [2];
  logic [1:0]      fifo_rresp [2];
  logic [ILEN-1:0] fifo_rid   [2];

  // The outstanding count doubles as the FIFO occupancy, so arready comes from
  // flops only and the FIFO can never be pushed while full.
  assign arready = run_reg && (outstanding_reg != 2'd2);
  assign rvalid  = (outstanding_reg != 2'd0);
  assign ar_hs   = bus.i_im_bus_arvalid && arready;
  assign r_hs    = rvalid && bus.i_im_bus_rready;

  assign misaligned = (bus.i_im_bus_araddr[1:0] != 2'b00);
  assign word_idx   = bus.i_im_bus_araddr[AW+1:2];

  generate
    if (XLEN > AW + 2) begin : g_range_check
      assign out_of_range = |bus.i_im_bus_araddr[XLEN-1:AW+2];
    end else begin : g_no_range_check
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Misalignment wins over decode errors.
  always_comb begin
    resp_code = RESP_OKAY;
    if (misaligned) begin
      resp_code = RESP_SLVERR;
    end else if (out_of_range) begin
      resp_code = RESP_DECERR;
    end
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({ar_hs, r_hs})
      2'b10:   outstanding_next = outstanding_reg + 2'd1;
      2'b01:   outstanding_next = outstanding_reg - 2'd1;
      default: outstanding_next = outstanding_reg;
    endcase
    wr_ptr_next = wr_ptr_reg ^ ar_hs;
    rd_ptr_next = rd_ptr_reg ^ r_hs;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_reg         <= 1'b0;
      outstanding_reg <= 2'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
    end else begin
      run_reg         <= 1'b1;
      outstanding_reg <= outstanding_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // Memory contents survive reset; a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (i_ld_we) begin
      mem[i_ld_addr] <= i_ld_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      fifo_rdata[wr_ptr_reg] <= (resp_code == RESP_OKAY) ? mem[word_idx] : '0;
      fifo_rresp[wr_ptr_reg] <= resp_code;
      fifo_rid[wr_ptr_reg]   <= bus.i_im_bus_arid;
    end
  end

  // Payload is forced to zero whenever the FIFO is empty, including in reset.
  assign bus.o_im_bus_arready = arready;
  assign bus.o_im_bus_rvalid  = rvalid;
  assign bus.o_im_bus_rdata   = rvalid ? fifo_rdata[rd_ptr_reg] : '0;
  assign bus.o_im_bus_rresp   = rvalid ? fifo_rresp[rd_ptr_reg] : 2'b00;
  assign bus.o_im_bus_rid     = rvalid ? fifo_rid[rd_ptr_reg]   : '0;
endmodule

// File: tb/tb_im_bus_read_responder.sv
// Directed bench for im_bus_read_responder: inputs change 1ns after the rising
// edge, outputs are checked on the falling edge.
module tb_im_bus_read_responder;
  localparam int XLEN  = 32;
  localparam int DLEN  = 32;
  localparam int ILEN  = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_wdata;

  int checks = 0;
  int errors = 0;

  im_bus_if #(.XLEN(XLEN), .DLEN(DLEN), .ILEN(ILEN)) bus ();

  im_bus_read_responder #(
    .XLEN(XLEN), .DLEN(DLEN), .ILEN(ILEN), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .i_ld_we    (ld_we),
    .i_ld_addr  (ld_addr),
    .i_ld_wdata (ld_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic v, input logic [31:0] a, input logic [3:0] id);
    bus.i_im_bus_arvalid = v;
    bus.i_im_bus_araddr  = a;
    bus.i_im_bus_arid    = id;
  endtask

  task automatic load(input logic [9:0] idx, input logic [31:0] d);
    ld_we    = 1'b1;
    ld_addr  = idx;
    ld_wdata = d;
    tick();
    ld_we    = 1'b0;
  endtask

  task automatic expect_r(input string tag, input logic v, input logic [31:0] d,
                          input logic [1:0] rs, input logic [3:0] id);
    chk({tag, "_rvalid"}, bus.o_im_bus_rvalid, v);
    if (v) begin
      chk({tag, "_rdata"}, bus.o_im_bus_rdata, d);
      chk({tag, "_rresp"}, bus.o_im_bus_rresp, rs);
      chk({tag, "_rid"}, bus.o_im_bus_rid, id);
    end
    $display("txn %s: rvalid=%0b rdata=%08h rresp=%0d rid=%0d arready=%0b", tag,
             bus.o_im_bus_rvalid, bus.o_im_bus_rdata, bus.o_im_bus_rresp,
             bus.o_im_bus_rid, bus.o_im_bus_arready);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    bus.i_im_bus_rready = 1'b0;
    ar(1'b0, 32'h0, 4'h0);
    repeat (2) tick();

    // Reset state
    @(negedge clk);
    chk("rst_arready", bus.o_im_bus_arready, 1'b0);
    chk("rst_rvalid",  bus.o_im_bus_rvalid, 1'b0);
    chk("rst_rdata",   bus.o_im_bus_rdata, 32'h0);
    chk("rst_rresp",   bus.o_im_bus_rresp, 2'b00);
    chk("rst_rid",     bus.o_im_bus_rid, 4'h0);
    tick();

    // Memory is writable regardless of reset
    load(10'd0, 32'h1111_1111);
    load(10'd1, 32'h2222_2222);
    load(10'd2, 32'h3333_3333);
    load(10'd5, 32'h00A0_0093);
    load(10'd6, 32'h6666_6666);
    load(10'd1023, 32'hDEAD_BEEF);

    rstn = 1'b1;
    @(negedge clk);
    chk("run_before_edge_arready", bus.o_im_bus_arready, 1'b0);
    tick();
    @(negedge clk);
    chk("run_after_edge_arready", bus.o_im_bus_arready, 1'b1);
    tick();

    // Single read of mem[5]
    bus.i_im_bus_rready = 1'b1;
    ar(1'b1, 32'h14, 4'd3);
    @(negedge clk);
    chk("single_arready", bus.o_im_bus_arready, 1'b1);
    chk("single_no_early_rvalid", bus.o_im_bus_rvalid, 1'b0);
    tick();
    ar(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    expect_r("single", 1'b1, 32'h00A0_0093, 2'b00, 4'd3);
    tick();
    @(negedge clk);
    expect_r("single_drained", 1'b0, 32'h0, 2'b00, 4'd0);
    tick();

    // Back-to-back reads with rready high
    ar(1'b1, 32'h0, 4'd1);
    @(negedge clk);
    chk("b2b0_arready", bus.o_im_bus_arready, 1'b1);
    tick();
    ar(1'b1, 32'h4, 4'd2);
    @(negedge clk);
    chk("b2b1_arready", bus.o_im_bus_arready, 1'b1);
    expect_r("b2b_r0", 1'b1, 32'h1111_1111, 2'b00, 4'd1);
    tick();
    ar(1'b1, 32'h8, 4'd4);
    @(negedge clk);
    chk("b2b2_arready", bus.o_im_bus_arready, 1'b1);
    expect_r("b2b_r1", 1'b1, 32'h2222_2222, 2'b00, 4'd2);
    tick();
    ar(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    expect_r("b2b_r2", 1'b1, 32'h3333_3333, 2'b00, 4'd4);
    tick();
    @(negedge clk);
    expect_r("b2b_drained", 1'b0, 32'h0, 2'b00, 4'd0);
    tick();

    // Backpressure: two accepted, third stalled
    bus.i_im_bus_rready = 1'b0;
    ar(1'b1, 32'h14, 4'd5);
    tick();
    ar(1'b1, 32'h4, 4'd6);
    @(negedge clk);
    chk("bp_second_arready", bus.o_im_bus_arready, 1'b1);
    tick();
    ar(1'b1, 32'h8, 4'd7);
    @(negedge clk);
    chk("bp_full_arready", bus.o_im_bus_arready, 1'b0);
    expect_r("bp_hold0", 1'b1, 32'h00A0_0093, 2'b00, 4'd5);
    tick();
    @(negedge clk);
    chk("bp_full_arready_hold", bus.o_im_bus_arready, 1'b0);
    expect_r("bp_hold1", 1'b1, 32'h00A0_0093, 2'b00, 4'd5);
    tick();
    ar(1'b0, 32'h0, 4'd0);
    bus.i_im_bus_rready = 1'b1;
    @(negedge clk);
    expect_r("bp_drain0", 1'b1, 32'h00A0_0093, 2'b00, 4'd5);
    tick();
    @(negedge clk);
    expect_r("bp_drain1", 1'b1, 32'h2222_2222, 2'b00, 4'd6);
    chk("bp_arready_back", bus.o_im_bus_arready, 1'b1);
    tick();
    @(negedge clk);
    expect_r("bp_empty", 1'b0, 32'h0, 2'b00, 4'd0);
    tick();

    // Error responses and address boundaries
    ar(1'b1, 32'h6, 4'd9);
    tick();
    ar(1'b1, 32'h1000, 4'd10);
    @(negedge clk);
    expect_r("err_misaligned", 1'b1, 32'h0, 2'b10, 4'd9);
    tick();
    ar(1'b1, 32'h1002, 4'd11);
    @(negedge clk);
    expect_r("err_decode", 1'b1, 32'h0, 2'b11, 4'd10);
    tick();
    ar(1'b1, 32'hFFC, 4'd12);
    @(negedge clk);
    expect_r("err_priority", 1'b1, 32'h0, 2'b10, 4'd11);
    tick();
    ar(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    expect_r("last_word", 1'b1, 32'hDEAD_BEEF, 2'b00, 4'd12);
    tick();

    // Read and load of the same word on one edge returns the old word
    ar(1'b1, 32'h18, 4'd8);
    ld_we = 1'b1; ld_addr = 10'd6; ld_wdata = 32'h7777_7777;
    tick();
    ld_we = 1'b0;
    ar(1'b1, 32'h18, 4'd9);
    @(negedge clk);
    expect_r("rdw_old", 1'b1, 32'h6666_6666, 2'b00, 4'd8);
    tick();
    ar(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    expect_r("rdw_new", 1'b1, 32'h7777_7777, 2'b00, 4'd9);
    tick();

    // Reset with two responses pending
    bus.i_im_bus_rready = 1'b0;
    ar(1'b1, 32'h0, 4'd1);
    tick();
    ar(1'b1, 32'h4, 4'd2);
    tick();
    ar(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    chk("pre_rst_rvalid", bus.o_im_bus_rvalid, 1'b1);
    chk("pre_rst_arready", bus.o_im_bus_arready, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_rvalid", bus.o_im_bus_rvalid, 1'b0);
    chk("midrst_arready", bus.o_im_bus_arready, 1'b0);
    chk("midrst_rdata", bus.o_im_bus_rdata, 32'h0);
    chk("midrst_rid", bus.o_im_bus_rid, 4'h0);
    bus.i_im_bus_rready = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_arready0", bus.o_im_bus_arready, 1'b0);
    expect_r("rel_no_stale0", 1'b0, 32'h0, 2'b00, 4'd0);
    tick();
    @(negedge clk);
    chk("rel_arready1", bus.o_im_bus_arready, 1'b1);
    expect_r("rel_no_stale1", 1'b0, 32'h0, 2'b00, 4'd0);
    tick();
    @(negedge clk);
    expect_r("rel_no_stale2", 1'b0, 32'h0, 2'b00, 4'd0);
    tick();

    // Normal operation after reset; memory contents retained
    ar(1'b1, 32'h14, 4'd3);
    tick();
    ar(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    expect_r("post_rst", 1'b1, 32'h00A0_0093, 2'b00, 4'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
